// File: rtl/ltpi_data_channel_arbiter_if.sv
// LTPI data-channel payload types and the handshake bundle
// between requesters, the arbiter and the TX/RX FIFOs.
package ltpi_dc_pkg;

  typedef enum logic [3:0] {
    READ_REQ   = 4'd0,
    WRITE_REQ  = 4'd1,
    READ_COMP  = 4'd2,
    WRITE_COMP = 4'd3,
    CRC_ERROR  = 4'd4
  } dc_cmd_t;

  typedef struct packed {
    dc_cmd_t     command;
    logic [7:0]  tag;
    logic [3:0]  byte_en;
    logic [31:0] address;
    logic [31:0] data;
  } Data_channel_payload_t;

endpackage

interface ltpi_data_channel_arbiter_if
  import ltpi_dc_pkg::*;
#(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]                  up_req_valid;
  Data_channel_payload_t [NUM_REQ-1:0] up_req;
  logic [NUM_REQ-1:0]                  up_req_ack;
  logic [NUM_REQ-1:0]                  up_resp_valid;
  Data_channel_payload_t               up_resp;
  logic                                dn_req_valid;
  Data_channel_payload_t               dn_req;
  logic                                dn_req_ack;
  logic                                dn_resp_valid;
  Data_channel_payload_t               dn_resp;

  modport slave (
    input  up_req_valid, up_req, dn_req_ack,
    input  dn_resp_valid, dn_resp,
    output up_req_ack, up_resp_valid, up_resp,
    output dn_req_valid, dn_req
  );

  modport master (
    output up_req_valid, up_req, dn_req_ack,
    output dn_resp_valid, dn_resp,
    input  up_req_ack, up_resp_valid, up_resp,
    input  dn_req_valid, dn_req
  );
endinterface

// File: rtl/ltpi_data_channel_arbiter.sv
// Round-robin arbiter sharing the LTPI data channel between
// requesters, with tag rewriting and per-requester timeouts.
module ltpi_data_channel_arbiter
  import ltpi_dc_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 65000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      data_channel_rst,
  ltpi_data_channel_arbiter_if.slave bus,
  output logic                      busy,
  output logic [NUM_REQ-1:0]        timeout_pulse,
  output logic [7:0]                drop_cnt
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int IW1   = IDX_W + 1;
  localparam int SEQ_W = 8 - IDX_W;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST =
    TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_ISSUE
  } arb_state_t;

  typedef logic [NUM_REQ-1:0] req_vec_t;

  arb_state_t            state_q, state_d;
  logic [IDX_W-1:0]      g_q, g_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  req_vec_t              outstanding_q, outstanding_d;
  req_vec_t              up_req_ack_q, up_req_ack_d;
  req_vec_t              up_resp_valid_q, up_resp_valid_d;
  req_vec_t              timeout_q, timeout_d;
  logic                  dn_req_valid_q, dn_req_valid_d;
  Data_channel_payload_t dn_req_q, dn_req_d;
  Data_channel_payload_t up_resp_q, up_resp_d;
  logic [SEQ_W-1:0]      seq_q [NUM_REQ];
  logic [SEQ_W-1:0]      seq_d [NUM_REQ];
  logic [7:0]            orig_tag_q [NUM_REQ];
  logic [7:0]            orig_tag_d [NUM_REQ];
  logic [7:0]            exp_tag_q [NUM_REQ];
  logic [7:0]            exp_tag_d [NUM_REQ];
  logic [TMR_W-1:0]      timer_q [NUM_REQ];
  logic [TMR_W-1:0]      timer_d [NUM_REQ];
  logic [7:0]            drop_q, drop_d;

  logic                  rst;
  logic                  found;
  logic [IDX_W-1:0]      gnt;
  logic [IW1-1:0]        idx;
  logic                  crc;
  req_vec_t              elig, hit, clr, expire;

  assign rst = reset | data_channel_rst;

  always_comb begin
    elig  = bus.up_req_valid & ~outstanding_q;
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr_q} + IW1'(k);
      if (idx >= IW1'(NUM_REQ))
        idx = idx - IW1'(NUM_REQ);
      if (!found && elig[idx[IDX_W-1:0]]) begin
        found = 1'b1;
        gnt   = idx[IDX_W-1:0];
      end
    end
  end

  // CRC_ERROR carries no usable tag: it completes every
  // outstanding transaction at once.
  always_comb begin
    crc = bus.dn_resp_valid &&
          (bus.dn_resp.command == CRC_ERROR);
    hit = '0;
    for (int r = 0; r < NUM_REQ; r++)
      hit[r] = bus.dn_resp_valid && !crc &&
               outstanding_q[r] &&
               (bus.dn_resp.tag[IDX_W-1:0] == IDX_W'(r)) &&
               (bus.dn_resp.tag == exp_tag_q[r]);
    clr    = crc ? outstanding_q : hit;
    expire = '0;
    for (int r = 0; r < NUM_REQ; r++)
      expire[r] = outstanding_q[r] && !clr[r] &&
                  (timer_q[r] == TMR_LAST);
  end

  always_comb begin
    state_d         = state_q;
    g_d             = g_q;
    rr_ptr_d        = rr_ptr_q;
    dn_req_d        = dn_req_q;
    dn_req_valid_d  = dn_req_valid_q;
    up_req_ack_d    = '0;
    seq_d           = seq_q;
    orig_tag_d      = orig_tag_q;
    exp_tag_d       = exp_tag_q;
    outstanding_d   = outstanding_q & ~clr & ~expire;
    timeout_d       = expire;
    up_resp_valid_d = clr;
    up_resp_d       = up_resp_q;
    drop_d          = drop_q;

    for (int r = 0; r < NUM_REQ; r++)
      timer_d[r] = outstanding_d[r] ?
                   timer_q[r] + 1'b1 : '0;

    if (crc) begin
      up_resp_d = bus.dn_resp;
    end else if (|hit) begin
      up_resp_d = bus.dn_resp;
      for (int r = 0; r < NUM_REQ; r++)
        if (hit[r])
          up_resp_d.tag = orig_tag_q[r];
    end else if (bus.dn_resp_valid &&
                 drop_q != 8'hFF) begin
      drop_d = drop_q + 8'd1;
    end

    unique case (state_q)
      ARB_IDLE: begin
        if (found) begin
          state_d         = ARB_ISSUE;
          g_d             = gnt;
          dn_req_d        = bus.up_req[gnt];
          dn_req_d.tag    = {seq_q[gnt], gnt};
          orig_tag_d[gnt] = bus.up_req[gnt].tag;
          dn_req_valid_d  = 1'b1;
        end
      end
      ARB_ISSUE: begin
        if (bus.dn_req_ack) begin
          state_d            = ARB_IDLE;
          dn_req_valid_d     = 1'b0;
          up_req_ack_d[g_q]  = 1'b1;
          outstanding_d[g_q] = 1'b1;
          exp_tag_d[g_q]     = dn_req_q.tag;
          seq_d[g_q]         = seq_q[g_q] + 1'b1;
          timer_d[g_q]       = '0;
          rr_ptr_d = (g_q == IDX_W'(NUM_REQ - 1)) ?
                     '0 : g_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ARB_IDLE;
      g_q             <= '0;
      rr_ptr_q        <= '0;
      outstanding_q   <= '0;
      up_req_ack_q    <= '0;
      up_resp_valid_q <= '0;
      timeout_q       <= '0;
      dn_req_valid_q  <= 1'b0;
      dn_req_q        <= '0;
      up_resp_q       <= '0;
      drop_q          <= '0;
      for (int r = 0; r < NUM_REQ; r++) begin
        seq_q[r]      <= '0;
        orig_tag_q[r] <= '0;
        exp_tag_q[r]  <= '0;
        timer_q[r]    <= '0;
      end
    end else begin
      state_q         <= state_d;
      g_q             <= g_d;
      rr_ptr_q        <= rr_ptr_d;
      outstanding_q   <= outstanding_d;
      up_req_ack_q    <= up_req_ack_d;
      up_resp_valid_q <= up_resp_valid_d;
      timeout_q       <= timeout_d;
      dn_req_valid_q  <= dn_req_valid_d;
      dn_req_q        <= dn_req_d;
      up_resp_q       <= up_resp_d;
      drop_q          <= drop_d;
      for (int r = 0; r < NUM_REQ; r++) begin
        seq_q[r]      <= seq_d[r];
        orig_tag_q[r] <= orig_tag_d[r];
        exp_tag_q[r]  <= exp_tag_d[r];
        timer_q[r]    <= timer_d[r];
      end
    end
  end

  assign bus.up_req_ack    = up_req_ack_q;
  assign bus.up_resp_valid = up_resp_valid_q;
  assign bus.up_resp       = up_resp_q;
  assign bus.dn_req_valid  = dn_req_valid_q;
  assign bus.dn_req        = dn_req_q;
  assign timeout_pulse     = timeout_q;
  assign drop_cnt          = drop_q;
  assign busy = (|outstanding_q) || (state_q != ARB_IDLE);

endmodule

// File: tb/tb_ltpi_data_channel_arbiter.sv
// Directed bench for ltpi_data_channel_arbiter with two
// requesters and a shortened response timeout.
module tb_ltpi_data_channel_arbiter;
  import ltpi_dc_pkg::*;

  logic       clk;
  logic       reset;
  logic       data_channel_rst;
  logic       busy;
  logic [1:0] timeout_pulse;
  logic [7:0] drop_cnt;
  int         n_tests;
  int         n_fail;
  int         n;

  ltpi_data_channel_arbiter_if #(.NUM_REQ(2)) bus ();

  ltpi_data_channel_arbiter #(
    .NUM_REQ       (2),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .data_channel_rst(data_channel_rst),
    .bus             (bus),
    .busy            (busy),
    .timeout_pulse   (timeout_pulse),
    .drop_cnt        (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic Data_channel_payload_t pl(
    input dc_cmd_t c, input logic [7:0] t,
    input logic [31:0] a, input logic [31:0] d);
    pl         = '0;
    pl.command = c;
    pl.tag     = t;
    pl.byte_en = 4'hF;
    pl.address = a;
    pl.data    = d;
  endfunction

  task automatic do_reset();
    reset             = 1'b1;
    bus.up_req_valid  = '0;
    bus.dn_req_ack    = 1'b0;
    bus.dn_resp_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_dn();
    for (int i = 0; i < 20 && bus.dn_req_valid !== 1'b1; i++)
      tick();
    chk("dn_req_valid_wait", 32'(bus.dn_req_valid), 1);
  endtask

  task automatic issue(input int idx,
                       input logic [7:0] etag,
                       input bit drop);
    wait_dn();
    chk("dn_req_tag", 32'(bus.dn_req.tag), 32'(etag));
    bus.dn_req_ack = 1'b1;
    tick();
    bus.dn_req_ack = 1'b0;
    chk("up_req_ack", 32'(bus.up_req_ack), 32'(1) << idx);
    chk("dn_req_valid_drop", 32'(bus.dn_req_valid), 0);
    if (drop)
      bus.up_req_valid[idx] = 1'b0;
  endtask

  task automatic respond(input dc_cmd_t c,
                         input logic [7:0] t);
    bus.dn_resp       = pl(c, t, 32'h0, 32'h5A5A_0000);
    bus.dn_resp_valid = 1'b1;
    tick();
    bus.dn_resp_valid = 1'b0;
  endtask

  initial begin
    n_tests           = 0;
    n_fail            = 0;
    reset             = 1'b1;
    data_channel_rst  = 1'b0;
    bus.up_req_valid  = '0;
    bus.up_req        = '0;
    bus.dn_req_ack    = 1'b0;
    bus.dn_resp_valid = 1'b0;
    bus.dn_resp       = '0;
    do_reset();

    chk("rst_dn_req_valid", 32'(bus.dn_req_valid), 0);
    chk("rst_up_req_ack", 32'(bus.up_req_ack), 0);
    chk("rst_up_resp_valid", 32'(bus.up_resp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_drop_cnt", 32'(drop_cnt), 0);
    chk("rst_timeout", 32'(timeout_pulse), 0);
    chk("rst_dn_req_tag", 32'(bus.dn_req.tag), 0);
    chk("rst_dn_req_cmd", 32'(bus.dn_req.command),
        32'(READ_REQ));
    chk("rst_up_resp_tag", 32'(bus.up_resp.tag), 0);

    // single write from requester 0
    bus.up_req[0] = pl(WRITE_REQ, 8'h33, 32'h100,
                       32'hDEAD_BEEF);
    bus.up_req_valid[0] = 1'b1;
    wait_dn();
    chk("wr_cmd", 32'(bus.dn_req.command), 32'(WRITE_REQ));
    chk("wr_addr", bus.dn_req.address, 32'h100);
    chk("wr_data", bus.dn_req.data, 32'hDEAD_BEEF);
    issue(0, 8'h00, 1'b1);
    chk("wr_busy", 32'(busy), 1);
    respond(WRITE_COMP, 8'h00);
    chk("wr_resp_valid", 32'(bus.up_resp_valid), 1);
    chk("wr_resp_tag", 32'(bus.up_resp.tag), 32'h33);
    chk("wr_resp_cmd", 32'(bus.up_resp.command),
        32'(WRITE_COMP));
    tick();
    chk("wr_resp_pulse", 32'(bus.up_resp_valid), 0);
    chk("wr_idle_busy", 32'(busy), 0);

    // alternating grants with immediate responses
    do_reset();
    bus.up_req[0] = pl(READ_REQ, 8'hA0, 32'h200, 32'h0);
    bus.up_req[1] = pl(READ_REQ, 8'hB1, 32'h300, 32'h0);
    bus.up_req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      issue(k % 2, 8'(k), 1'b0);
      respond(READ_COMP, 8'(k));
      chk("rr_resp_valid", 32'(bus.up_resp_valid),
          32'(1) << (k % 2));
      chk("rr_resp_tag", 32'(bus.up_resp.tag),
          (k % 2) ? 32'hB1 : 32'hA0);
    end
    issue(0, 8'h04, 1'b0);
    wait_dn();
    chk("rr_fifth_tag", 32'(bus.dn_req.tag), 32'h05);

    // reset while a request is waiting for its ack
    data_channel_rst = 1'b1;
    tick();
    data_channel_rst = 1'b0;
    chk("dcrst_dn_req_valid", 32'(bus.dn_req_valid), 0);
    chk("dcrst_up_req_ack", 32'(bus.up_req_ack), 0);
    chk("dcrst_busy", 32'(busy), 0);
    tick();
    chk("dcrst_regrant", 32'(bus.dn_req_valid), 1);
    chk("dcrst_regrant_tag", 32'(bus.dn_req.tag), 32'h00);

    // unmatched responses and drop counter saturation
    do_reset();
    bus.up_req_valid[1] = 1'b1;
    issue(1, 8'h01, 1'b1);
    respond(READ_COMP, 8'h01);
    chk("r1_resp_valid", 32'(bus.up_resp_valid), 2);
    bus.up_req_valid[1] = 1'b1;
    issue(1, 8'h03, 1'b1);
    respond(READ_COMP, 8'h05);
    chk("drop_no_resp", 32'(bus.up_resp_valid), 0);
    chk("drop_cnt_1", 32'(drop_cnt), 1);
    respond(READ_COMP, 8'h03);
    chk("r1_match_valid", 32'(bus.up_resp_valid), 2);
    chk("r1_match_tag", 32'(bus.up_resp.tag), 32'hB1);
    bus.dn_resp       = pl(READ_COMP, 8'h05, 32'h0, 32'h0);
    bus.dn_resp_valid = 1'b1;
    repeat (199) tick();
    chk("drop_cnt_200", 32'(drop_cnt), 200);
    repeat (100) tick();
    bus.dn_resp_valid = 1'b0;
    chk("drop_cnt_sat", 32'(drop_cnt), 32'hFF);

    // timeout and late response
    do_reset();
    bus.up_req[0] = pl(READ_REQ, 8'h33, 32'h400, 32'h0);
    bus.up_req_valid[0] = 1'b1;
    issue(0, 8'h00, 1'b1);
    n = 0;
    while (n < 200 && timeout_pulse[0] !== 1'b1) begin
      tick();
      n++;
    end
    chk("timeout_cycles", 32'(n), 100);
    chk("timeout_busy", 32'(busy), 0);
    tick();
    chk("timeout_pulse_len", 32'(timeout_pulse), 0);
    respond(READ_COMP, 8'h00);
    chk("late_no_resp", 32'(bus.up_resp_valid), 0);
    chk("late_drop", 32'(drop_cnt), 1);

    // CRC error completes both outstanding requesters
    do_reset();
    bus.up_req_valid = 2'b11;
    issue(0, 8'h00, 1'b1);
    issue(1, 8'h01, 1'b1);
    chk("crc_busy_before", 32'(busy), 1);
    respond(CRC_ERROR, 8'h77);
    chk("crc_resp_valid", 32'(bus.up_resp_valid), 3);
    chk("crc_resp_cmd", 32'(bus.up_resp.command),
        32'(CRC_ERROR));
    chk("crc_resp_tag", 32'(bus.up_resp.tag), 32'h77);
    tick();
    chk("crc_resp_pulse", 32'(bus.up_resp_valid), 0);
    chk("crc_busy_after", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
